tls_cmd_ctrl: RTL and testbench

Byte-stream command front end for the traffic-light sequencer. Accepts opcode/data bytes over a valid/ready interface, assembles and validates SET frames carrying green/yellow/red durations, and drives the sequencer's `set`/`stop`/`jump` controls and `gin`/`yin`/`rin` duration buses. The block sits directly upstream of the light FSM. It guarantees the duration buses are stable before and during every `set` pulse, and that `set` and `jump` are clean one-cycle pulses.

---
 rtl/tls_pkg.sv | 25 ++
 rtl/tls_cmd_if.sv | 11 +
 rtl/tls_frame_timer.sv | 38 +++
 rtl/tls_cmd_ctrl.sv | 144 ++++++++++++++
 tb/tb_tls_cmd_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tls_pkg.sv
// Shared opcodes, FSM state encoding and data-byte check for the traffic-light command front end.
package tls_pkg;

    localparam int unsigned DUR_W = 4;

    localparam logic [7:0] OP_SET      = 8'h10;
    localparam logic [7:0] OP_JUMP     = 8'h20;
    localparam logic [7:0] OP_STOP_ON  = 8'h30;
    localparam logic [7:0] OP_STOP_OFF = 8'h31;

    typedef enum logic [2:0] {
        StIdle,
        StGetG,
        StGetY,
        StGetR,
        StLoad,
        StFire
    } tls_state_e;

    // A duration byte must have a zero upper nibble and a nonzero lower nibble.
    function automatic logic data_ok(input logic [7:0] b);
        return (b[7:4] == 4'h0) && (b[3:0] != 4'h0);
    endfunction

endpackage

// File: rtl/tls_cmd_if.sv
// Byte-stream valid/ready channel feeding the command front end.
interface tls_cmd_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/tls_frame_timer.sv
// Saturating inter-byte idle counter; flags the cycle on which the count reaches Timeout.
module tls_frame_timer #(
    parameter int unsigned Timeout = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(Timeout + 1);
    localparam logic [CntW-1:0] Limit   = CntW'(Timeout);
    localparam logic [CntW-1:0] LimitM1 = CntW'(Timeout - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expires on the idle cycle whose increment lands the count on Limit.
    assign expired_o = en_i && !clr_i && (cnt_q >= LimitM1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tls_cmd_ctrl.sv
// Command front end: decodes opcodes, assembles SET frames and drives sequencer controls.
module tls_cmd_ctrl
    import tls_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    tls_cmd_if.slave         cmd,
    output logic             set_o,
    output logic             stop_o,
    output logic             jump_o,
    output logic [DUR_W-1:0] gin_o,
    output logic [DUR_W-1:0] yin_o,
    output logic [DUR_W-1:0] rin_o,
    output logic             err_o,
    output logic             busy_o
);

    tls_state_e state_q, state_d;

    logic [DUR_W-1:0] sh_g_q, sh_g_d, sh_y_q, sh_y_d, sh_r_q, sh_r_d;
    logic [DUR_W-1:0] gin_q, gin_d, yin_q, yin_d, rin_q, rin_d;
    logic             stop_q, stop_d;
    logic             set_q, set_d, jump_q, jump_d, err_q, err_d, busy_q;

    logic accept, in_get, expired;

    assign in_get        = (state_q == StGetG) || (state_q == StGetY) || (state_q == StGetR);
    assign cmd.in_ready  = (state_q == StIdle) || in_get;
    assign accept        = cmd.in_valid && cmd.in_ready;

    tls_frame_timer #(
        .Timeout (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     ((state_q == StIdle) || accept),
        .en_i      (in_get),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        sh_g_d  = sh_g_q;
        sh_y_d  = sh_y_q;
        sh_r_d  = sh_r_q;
        gin_d   = gin_q;
        yin_d   = yin_q;
        rin_d   = rin_q;
        stop_d  = stop_q;
        set_d   = 1'b0;
        jump_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (cmd.in_data)
                        OP_SET:      state_d = StGetG;
                        OP_JUMP:     jump_d  = 1'b1;
                        OP_STOP_ON:  stop_d  = 1'b1;
                        OP_STOP_OFF: stop_d  = 1'b0;
                        default:     err_d   = 1'b1;
                    endcase
                end
            end
            StGetG, StGetY, StGetR: begin
                if ((accept && !data_ok(cmd.in_data)) || (!accept && expired)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                    sh_g_d  = '0;
                    sh_y_d  = '0;
                    sh_r_d  = '0;
                end else if (accept) begin
                    unique case (state_q)
                        StGetG: begin
                            sh_g_d  = cmd.in_data[DUR_W-1:0];
                            state_d = StGetY;
                        end
                        StGetY: begin
                            sh_y_d  = cmd.in_data[DUR_W-1:0];
                            state_d = StGetR;
                        end
                        default: begin
                            // Live buses update on entry to LOAD so they are settled a cycle before set.
                            sh_r_d  = cmd.in_data[DUR_W-1:0];
                            gin_d   = sh_g_q;
                            yin_d   = sh_y_q;
                            rin_d   = cmd.in_data[DUR_W-1:0];
                            state_d = StLoad;
                        end
                    endcase
                end
            end
            StLoad: begin
                set_d   = 1'b1;
                state_d = StFire;
            end
            StFire:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sh_g_q  <= '0;
            sh_y_q  <= '0;
            sh_r_q  <= '0;
            gin_q   <= '0;
            yin_q   <= '0;
            rin_q   <= '0;
            stop_q  <= 1'b0;
            set_q   <= 1'b0;
            jump_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_g_q  <= sh_g_d;
            sh_y_q  <= sh_y_d;
            sh_r_q  <= sh_r_d;
            gin_q   <= gin_d;
            yin_q   <= yin_d;
            rin_q   <= rin_d;
            stop_q  <= stop_d;
            set_q   <= set_d;
            jump_q  <= jump_d;
            err_q   <= err_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign set_o  = set_q;
    assign stop_o = stop_q;
    assign jump_o = jump_q;
    assign gin_o  = gin_q;
    assign yin_o  = yin_q;
    assign rin_o  = rin_q;
    assign err_o  = err_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_tls_cmd_ctrl.sv
// Directed self-checking bench for tls_cmd_ctrl with TIMEOUT=8.
module tb_tls_cmd_ctrl;
    import tls_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             set_o, stop_o, jump_o, err_o, busy_o;
    logic [DUR_W-1:0] gin_o, yin_o, rin_o;

    int checks = 0;
    int errors = 0;
    int set_cnt = 0, jump_cnt = 0, err_cnt = 0, pulse_viol = 0;
    logic set_prev = 1'b0, jump_prev = 1'b0;

    tls_cmd_if cmd_if ();

    tls_cmd_ctrl #(
        .TIMEOUT (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cmd    (cmd_if),
        .set_o  (set_o),
        .stop_o (stop_o),
        .jump_o (jump_o),
        .gin_o  (gin_o),
        .yin_o  (yin_o),
        .rin_o  (rin_o),
        .err_o  (err_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    // Pre-edge values: counts each cycle's output once, at the end of that cycle.
    always @(posedge clk) begin
        if (set_o) set_cnt++;
        if (jump_o) jump_cnt++;
        if (err_o) err_cnt++;
        if ((set_o && jump_o) || (set_o && set_prev) || (jump_o && jump_prev)) pulse_viol++;
        set_prev  = set_o;
        jump_prev = jump_o;
    end

    task automatic send(input logic [7:0] b);
        cmd_if.in_valid = 1'b1;
        cmd_if.in_data  = b;
        @(negedge clk);
        cmd_if.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({cmd_if.in_ready, busy_o, set_o, stop_o, jump_o, err_o, gin_o, yin_o, rin_o}
            !== {6'b100000, 12'h000}) begin
            errors++;
            $display("FAIL reset_held: got rdy/busy/set/stop/jump/err=%b%b%b%b%b%b g/y/r=%h%h%h want 100000 000",
                     cmd_if.in_ready, busy_o, set_o, stop_o, jump_o, err_o, gin_o, yin_o, rin_o);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_if.in_ready, busy_o, set_o, stop_o, jump_o, err_o, gin_o, yin_o, rin_o}
            !== {6'b100000, 12'h000}) begin
            errors++;
            $display("FAIL reset_released: got rdy/busy/set/stop/jump/err=%b%b%b%b%b%b g/y/r=%h%h%h want 100000 000",
                     cmd_if.in_ready, busy_o, set_o, stop_o, jump_o, err_o, gin_o, yin_o, rin_o);
        end
    endtask

    task automatic test_set_frame;
        int s0 = set_cnt;
        send(8'h10); send(8'h03); send(8'h02); send(8'h04);
        checks++;
        if ({gin_o, yin_o, rin_o} !== 12'h324) begin
            errors++;
            $display("FAIL set_durations: got %h%h%h want 324", gin_o, yin_o, rin_o);
        end
        checks++;
        if ({set_o, cmd_if.in_ready, busy_o} !== 3'b001) begin
            errors++;
            $display("FAIL set_load_cycle: set/rdy/busy=%b%b%b want 001", set_o, cmd_if.in_ready, busy_o);
        end
        @(negedge clk);
        checks++;
        if ({set_o, cmd_if.in_ready, busy_o} !== 3'b101) begin
            errors++;
            $display("FAIL set_fire_cycle: set/rdy/busy=%b%b%b want 101", set_o, cmd_if.in_ready, busy_o);
        end
        @(negedge clk);
        checks++;
        if ({set_o, cmd_if.in_ready, busy_o} !== 3'b010) begin
            errors++;
            $display("FAIL set_after: set/rdy/busy=%b%b%b want 010", set_o, cmd_if.in_ready, busy_o);
        end
        checks++;
        if (set_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL set_pulse_count: got %0d want 1", set_cnt - s0);
        end
    endtask

    task automatic test_stop_jump;
        int j0 = jump_cnt;
        checks++;
        if (stop_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_initial: got %b want 0", stop_o);
        end
        send(8'h30);
        checks++;
        if ({stop_o, jump_o} !== 2'b10) begin
            errors++;
            $display("FAIL stop_on: stop/jump=%b%b want 10", stop_o, jump_o);
        end
        send(8'h20);
        checks++;
        if ({stop_o, jump_o, set_o} !== 3'b110) begin
            errors++;
            $display("FAIL jump_pulse: stop/jump/set=%b%b%b want 110", stop_o, jump_o, set_o);
        end
        @(negedge clk);
        checks++;
        if (jump_o !== 1'b0) begin
            errors++;
            $display("FAIL jump_single: got %b want 0", jump_o);
        end
        send(8'h31);
        checks++;
        if (stop_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_off: got %b want 0", stop_o);
        end
        checks++;
        if (jump_cnt - j0 !== 1) begin
            errors++;
            $display("FAIL jump_count: got %0d want 1", jump_cnt - j0);
        end
    endtask

    task automatic test_bad_data(input logic [7:0] y);
        int s0 = set_cnt;
        send(8'h10); send(8'h07); send(y);
        checks++;
        if ({err_o, busy_o, cmd_if.in_ready} !== 3'b101) begin
            errors++;
            $display("FAIL bad_data_%h: err/busy/rdy=%b%b%b want 101", y, err_o, busy_o, cmd_if.in_ready);
        end
        checks++;
        if ({gin_o, yin_o, rin_o} !== 12'h324) begin
            errors++;
            $display("FAIL bad_data_%h_hold: got %h%h%h want 324", y, gin_o, yin_o, rin_o);
        end
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_data_%h_err_single: got %b want 0", y, err_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (set_cnt !== s0) begin
            errors++;
            $display("FAIL bad_data_%h_no_set: got %0d set pulses want 0", y, set_cnt - s0);
        end
    endtask

    task automatic test_bad_opcode;
        send(8'h7F);
        checks++;
        if ({err_o, busy_o, cmd_if.in_ready} !== 3'b101) begin
            errors++;
            $display("FAIL bad_opcode: err/busy/rdy=%b%b%b want 101", err_o, busy_o, cmd_if.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({err_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL bad_opcode_after: err/busy=%b%b want 00", err_o, busy_o);
        end
    endtask

    task automatic test_timeout;
        int s0 = set_cnt;
        send(8'h10); send(8'h05);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (err_o !== (k == 9)) begin
                errors++;
                $display("FAIL timeout_err_k%0d: got %b want %b", k, err_o, (k == 9));
            end
            if (k == 8 || k == 9) begin
                checks++;
                if (busy_o !== (k == 8)) begin
                    errors++;
                    $display("FAIL timeout_busy_k%0d: got %b want %b", k, busy_o, (k == 8));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (set_cnt !== s0 || {gin_o, yin_o, rin_o} !== 12'h324) begin
            errors++;
            $display("FAIL timeout_no_set: sets=%0d g/y/r=%h%h%h want 0 324",
                     set_cnt - s0, gin_o, yin_o, rin_o);
        end
    endtask

    task automatic test_reset_midframe;
        int s0;
        send(8'h30); send(8'h10); send(8'h09);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({cmd_if.in_ready, busy_o, set_o, stop_o, jump_o, err_o, gin_o, yin_o, rin_o}
            !== {6'b100000, 12'h000}) begin
            errors++;
            $display("FAIL reset_midframe: got rdy/busy/set/stop/jump/err=%b%b%b%b%b%b g/y/r=%h%h%h want 100000 000",
                     cmd_if.in_ready, busy_o, set_o, stop_o, jump_o, err_o, gin_o, yin_o, rin_o);
        end
        @(negedge clk);
        reset = 1'b0;
        s0 = set_cnt;
        send(8'h10); send(8'h01); send(8'h01); send(8'h01);
        checks++;
        if ({gin_o, yin_o, rin_o, stop_o} !== 13'b0001_0001_0001_0) begin
            errors++;
            $display("FAIL post_reset_frame: g/y/r=%h%h%h stop=%b want 111 0", gin_o, yin_o, rin_o, stop_o);
        end
        @(negedge clk);
        checks++;
        if (set_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_set: got %b want 1", set_o);
        end
        @(negedge clk);
        checks++;
        if (set_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL post_reset_set_count: got %0d want 1", set_cnt - s0);
        end
    endtask

    task automatic test_random_gaps;
        logic [7:0] bytes [4];
        int e0 = err_cnt;
        int s0 = set_cnt;
        bytes[0] = 8'h10; bytes[1] = 8'h0F; bytes[2] = 8'h08; bytes[3] = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            int gap = $urandom_range(0, 5);
            repeat (gap) begin
                cmd_if.in_data = 8'($urandom_range(0, 255));
                @(negedge clk);
            end
            send(bytes[i]);
        end
        checks++;
        if ({gin_o, yin_o, rin_o} !== 12'hF8A) begin
            errors++;
            $display("FAIL gaps_durations: got %h%h%h want F8A", gin_o, yin_o, rin_o);
        end
        @(negedge clk);
        checks++;
        if (set_o !== 1'b1) begin
            errors++;
            $display("FAIL gaps_set: got %b want 1", set_o);
        end
        @(negedge clk);
        checks++;
        if (err_cnt !== e0 || set_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL gaps_counts: errs=%0d sets=%0d want 0 1", err_cnt - e0, set_cnt - s0);
        end
        checks++;
        if (pulse_viol !== 0) begin
            errors++;
            $display("FAIL pulse_shape: got %0d overlapping/stretched pulses want 0", pulse_viol);
        end
    endtask

    initial begin
        cmd_if.in_valid = 1'b0;
        cmd_if.in_data  = 8'h00;
        test_reset();
        test_set_frame();
        test_stop_jump();
        test_bad_data(8'h00);
        test_bad_data(8'h15);
        test_bad_opcode();
        test_timeout();
        test_reset_midframe();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
